id_ex_stage: RTL
================

Name: id_ex_stage

Overview:
Decode-to-execute pipeline register that sits directly downstream of the register file. It captures the register file's two read ports plus decode control and resolves operands through forwarding from the EX, MEM and WB stages, including the same-cycle write/read case. It detects load-use hazards, stalls the front end and inserts a bubble. It also supports flush from branch resolution.

Parameters:
DATA_W, 32, datapath width
ADDR_W, 5, register address width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  decode slot holds a real instruction
id_rs  in  ADDR_W  source A address (same value driven to regfile reg1ad)
id_rt  in  ADDR_W  source B address (same value driven to regfile reg2ad)
id_rt_used  in  1  instruction reads rt as a register operand
id_dest  in  ADDR_W  destination register
id_reg_write  in  1  instruction writes dest
id_mem_read  in  1  instruction is a load
id_use_imm  in  1  operand B is the immediate
id_imm  in  DATA_W  sign-extended immediate
rs_data  in  DATA_W  regfile reg1data
rt_data  in  DATA_W  regfile reg2data
ex_result  in  DATA_W  ALU result of the instruction currently in EX
mem_dest, wb_dest  in  ADDR_W  destinations in MEM and WB
mem_reg_write, wb_reg_write  in  1  MEM and WB write enables (wb_reg_write also drives regfile RegWrite)
mem_result, wb_result  in  DATA_W  MEM and WB results
flush  in  1  kill the instruction entering EX
stall  out  1  combinational; hold PC and IF/ID
ex_valid  out  1  EX slot valid
ex_opa, ex_opb, ex_store_data  out  DATA_W  resolved operands
ex_dest  out  ADDR_W  registered dest
ex_reg_write, ex_mem_read  out  1  registered controls
stall_count  out  32  load-use stall counter (see Optional Feature)

Behaviour:
- Reset (rst_n=0, asynchronous) clears every registered output to 0: ex_valid, operands, dest, controls, stall_count.
- Latency: one cycle from decode inputs to ex_* outputs.
- Operand resolution is combinational before capture. The same rule applies independently to rs and rt. Priority is highest first:
  - EX: ex_valid & ex_reg_write & !ex_mem_read & ex_dest==addr → ex_result
  - MEM: mem_reg_write & mem_dest==addr → mem_result
  - WB: wb_reg_write & wb_dest==addr → wb_result. This covers the register file writing and reading the same address in the same cycle.
  - Otherwise the regfile data is used.
- Address 0 is never forwarded; it always resolves to 0 regardless of regfile contents.
- ex_opb = id_use_imm ? id_imm : resolved rt. ex_store_data = resolved rt.
- Load-use hazard: stall = id_valid & ex_valid & ex_mem_read & ex_dest!=0 & (ex_dest==id_rs | (id_rt_used & ex_dest==id_rt)). While stall=1, the next edge loads a bubble: ex_valid=0, ex_reg_write=0, ex_mem_read=0. Data fields are don't-care.
- A stall lasts exactly one cycle, because the load has moved to MEM on the following cycle and forwards from there.
- flush=1: the next edge loads a bubble. flush has priority over stall, and stall is still driven per the rule above.
- id_valid=0: load a bubble.
- A bubble never asserts ex_reg_write or ex_mem_read, so it cannot trigger forwarding or a stall.
- Reset asserted mid-stall: stall drops immediately because ex_valid clears asynchronously.

Optional Feature:
Macro STALL_COUNT_EN.
- Defined: stall_count increments by 1 on each clock edge where stall=1 and flush=0. It saturates at 32'hFFFFFFFF and clears on reset.
- Undefined: stall_count is tied to 0 and no counter logic is built.

Test Plan:
- Reset, then id_valid=1, rs=3, rt=4, rs_data=10, rt_data=20, no forwarding → next cycle ex_valid=1, ex_opa=10, ex_opb=20, stall never asserted.
- EX holds dest=5 with ex_result=0x77; MEM holds dest=5 with mem_result=0x11; decode rs=5 → ex_opa=0x77 (EX beats MEM). Repeat with EX invalid → 0x11.
- wb_reg_write=1, wb_dest=7, wb_result=0xABCD, rs_data=0 (stale), rs=7 → ex_opa=0xABCD.
- Load to dest=8 in EX, decode rt=8 with id_rt_used=1 → stall=1 for exactly one cycle and a bubble enters EX. Next cycle rt forwards from MEM. With STALL_COUNT_EN defined, stall_count=1.
- rs=0 while MEM writes dest=0 with 0x55 and rs_data=0x99 → ex_opa=0. flush=1 together with a valid, stalling decode → ex_valid=0 next cycle.
- rst_n pulsed low between clock edges during a stall → all outputs 0 immediately, stall=0.

Source files
------------

// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
//
// Decode-to-execute pipeline register placed directly after the register file.
// It captures both regfile read ports and the decode controls, and resolves
// each source operand by forwarding from EX, MEM or WB, so a register written
// and read in the same cycle still gets the new value. A load in EX whose
// destination is needed by the decoding instruction raises a one-cycle stall
// and a bubble enters EX. A branch flush also turns the entering slot into a
// bubble.
//
// Optional feature (compile-time macro STALL_COUNT_EN):
//   defined   - stall_count counts edges with stall=1 and flush=0 and
//               saturates at all ones
//   undefined - stall_count is tied to 0 and no counter is built
//
// Parameters:
//   DATA_W   datapath width
//   ADDR_W   register address width
//
// Ports:
//   clk, rst_n                    clock (rising edge), async active-low reset
//   id_valid                      decode slot holds a real instruction
//   id_rs, id_rt                  source addresses (also drive the regfile)
//   id_rt_used                    rt is read as a register operand
//   id_dest, id_reg_write         destination register and its write enable
//   id_mem_read                   instruction is a load
//   id_use_imm, id_imm            operand B select and sign-extended immediate
//   rs_data, rt_data              regfile read data
//   ex_result                     ALU result of the instruction now in EX
//   mem_dest/_reg_write/_result   MEM stage writeback information
//   wb_dest/_reg_write/_result    WB stage writeback information
//   flush                         kill the instruction entering EX
//   stall                         combinational load-use stall to the front end
//   ex_valid, ex_dest             registered EX slot valid and destination
//   ex_reg_write, ex_mem_read     registered EX controls
//   ex_opa, ex_opb, ex_store_data resolved operands
//   stall_count                   load-use stall counter
// -----------------------------------------------------------------------------
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [ADDR_W-1:0] id_rs,
    input  logic [ADDR_W-1:0] id_rt,
    input  logic              id_rt_used,
    input  logic [ADDR_W-1:0] id_dest,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_use_imm,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [DATA_W-1:0] rs_data,
    input  logic [DATA_W-1:0] rt_data,
    input  logic [DATA_W-1:0] ex_result,
    input  logic [ADDR_W-1:0] mem_dest,
    input  logic              mem_reg_write,
    input  logic [DATA_W-1:0] mem_result,
    input  logic [ADDR_W-1:0] wb_dest,
    input  logic              wb_reg_write,
    input  logic [DATA_W-1:0] wb_result,
    input  logic              flush,
    output logic              stall,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_opa,
    output logic [DATA_W-1:0] ex_opb,
    output logic [DATA_W-1:0] ex_store_data,
    output logic [ADDR_W-1:0] ex_dest,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic [31:0]       stall_count
);

    logic              vld_p1;
    logic              reg_write_p1;
    logic              mem_read_p1;
    logic [ADDR_W-1:0] dest_p1;
    logic [DATA_W-1:0] opa_p1;
    logic [DATA_W-1:0] opb_p1;
    logic [DATA_W-1:0] store_p1;

    logic              ex_fwd_en;
    logic              bubble;
    logic [DATA_W-1:0] rs_fwd;
    logic [DATA_W-1:0] rt_fwd;

    // Youngest producer wins. A load in EX has no data yet, so it is excluded
    // from EX forwarding (the stall covers that case). Register 0 is hardwired.
    function automatic logic [DATA_W-1:0] fwd_operand(
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] rf_data,
        input logic              ex_en,
        input logic [ADDR_W-1:0] ex_addr,
        input logic [DATA_W-1:0] ex_data,
        input logic              mem_en,
        input logic [ADDR_W-1:0] mem_addr,
        input logic [DATA_W-1:0] mem_data,
        input logic              wb_en,
        input logic [ADDR_W-1:0] wb_addr,
        input logic [DATA_W-1:0] wb_data
    );
        logic [DATA_W-1:0] res;
        if (addr == '0)
            res = '0;
        else if (ex_en && (ex_addr == addr))
            res = ex_data;
        else if (mem_en && (mem_addr == addr))
            res = mem_data;
        else if (wb_en && (wb_addr == addr))
            res = wb_data;
        else
            res = rf_data;
        return res;
    endfunction

    // ---- decode stage: operand resolution and hazard detection (p0) ----
    assign ex_fwd_en = vld_p1 & reg_write_p1 & ~mem_read_p1;

    assign rs_fwd = fwd_operand(id_rs, rs_data, ex_fwd_en, dest_p1, ex_result,
                                mem_reg_write, mem_dest, mem_result,
                                wb_reg_write, wb_dest, wb_result);
    assign rt_fwd = fwd_operand(id_rt, rt_data, ex_fwd_en, dest_p1, ex_result,
                                mem_reg_write, mem_dest, mem_result,
                                wb_reg_write, wb_dest, wb_result);

    assign stall = id_valid & vld_p1 & mem_read_p1 & (dest_p1 != '0) &
                   ((dest_p1 == id_rs) | (id_rt_used & (dest_p1 == id_rt)));

    assign bubble = flush | stall | ~id_valid;

    // ---- ID/EX register (p1) ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1       <= 1'b0;
            reg_write_p1 <= 1'b0;
            mem_read_p1  <= 1'b0;
            dest_p1      <= '0;
            opa_p1       <= '0;
            opb_p1       <= '0;
            store_p1     <= '0;
        end else begin
            // A bubble clears only the controls; its data fields are never used.
            vld_p1       <= ~bubble;
            reg_write_p1 <= ~bubble & id_reg_write;
            mem_read_p1  <= ~bubble & id_mem_read;
            dest_p1      <= id_dest;
            opa_p1       <= rs_fwd;
            opb_p1       <= id_use_imm ? id_imm : rt_fwd;
            store_p1     <= rt_fwd;
        end
    end

    assign ex_valid      = vld_p1;
    assign ex_reg_write  = reg_write_p1;
    assign ex_mem_read   = mem_read_p1;
    assign ex_dest       = dest_p1;
    assign ex_opa        = opa_p1;
    assign ex_opb        = opb_p1;
    assign ex_store_data = store_p1;

`ifdef STALL_COUNT_EN
    logic [31:0] stall_cnt_p1;

    // Stalls overridden by a flush are not counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt_p1 <= '0;
        else if (stall && !flush && (stall_cnt_p1 != 32'hFFFF_FFFF))
            stall_cnt_p1 <= stall_cnt_p1 + 32'd1;
    end

    assign stall_count = stall_cnt_p1;
`else
    assign stall_count = 32'd0;
`endif

endmodule
